// File: rtl/mac_accumulator_pkg.sv
// Shared constants for the MAC accumulator slice: default widths, cfg codes
// and the accumulator FSM state encoding.
package mac_accumulator_pkg;

  // Default lane accumulator width and minimum operand width.
  localparam int MAC_ACC_WIDTH = 32;
  localparam int MAC_MIN_WIDTH = 8;

  // cfg codes forwarded to mac_combiner.
  localparam logic [1:0] MAC_SINGLE = 2'd0;
  localparam logic [1:0] MAC_DUAL   = 2'd1;
  localparam logic [1:0] MAC_QUAD   = 2'd2;

  // IDLE: waiting for the first beat of a dot product; ACC: mid dot product.
  typedef enum logic {
    MAC_ACC_IDLE = 1'b0,
    MAC_ACC_ACC  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/mac_acc_lane.sv
// One accumulator lane: running-sum register, adder with carry-out detection,
// optional saturation and a sticky overflow flag.
// MAC_ACC_SAT_EN defined: a carry clamps the lane to all-ones.
// sum/ovf present the lane value after the current beat, so the parent can
// capture the final result in the same clock as the last beat.
module mac_acc_lane #(
  parameter int ACC_WIDTH  = 32,
  parameter int PROD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  add,
  input  logic [PROD_WIDTH-1:0] prod,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  ovf
);

  logic [ACC_WIDTH-1:0] acc;
  logic                 acc_ovf;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH:0]   wide;
  logic                 carry;

  assign prod_ext = ACC_WIDTH'(prod);
  assign wide     = {1'b0, acc} + {1'b0, prod_ext};
  assign carry    = wide[ACC_WIDTH];

  // Lane value after this beat: first beat replaces, later beats add.
  always_comb begin
    sum = acc;
    ovf = acc_ovf;
    if (load) begin
      sum = prod_ext;
      ovf = 1'b0;
    end else if (add) begin
`ifdef MAC_ACC_SAT_EN
      // Once clamped, any further add carries again (or adds zero), so the
      // lane stays at all-ones for the rest of the dot product.
      sum = carry ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
`else
      sum = wide[ACC_WIDTH-1:0];
`endif
      ovf = acc_ovf | carry;
    end
  end

  // Accumulator register; cleared once its result has been handed off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (load || add) begin
      acc     <= sum;
      acc_ovf <= ovf;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Four-lane unsigned accumulator feeding mac_combiner. Sums per-lane products
// over one dot product and holds the lane sums plus captured cfg in result
// registers behind a valid/ready handshake; a held result stalls input.
// Optional feature macro: MAC_ACC_SAT_EN (per-lane saturation instead of wrap).
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH  = MAC_ACC_WIDTH,
  parameter int PROD_WIDTH = 2 * MAC_MIN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cfg,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [PROD_WIDTH-1:0] prod0,
  input  logic [PROD_WIDTH-1:0] prod1,
  input  logic [PROD_WIDTH-1:0] prod2,
  input  logic [PROD_WIDTH-1:0] prod3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  partial0,
  output logic [ACC_WIDTH-1:0]  partial1,
  output logic [ACC_WIDTH-1:0]  partial2,
  output logic [ACC_WIDTH-1:0]  partial3,
  output logic [1:0]            out_cfg,
  output logic [3:0]            ovf
);

  acc_state_t            state;
  logic [1:0]            cfg_hold;
  logic                  accept;
  logic                  result_load;
  logic                  lane_load;
  logic                  lane_add;
  logic [PROD_WIDTH-1:0] prod_arr [4];
  logic [ACC_WIDTH-1:0]  lane_sum [4];
  logic [3:0]            lane_ovf;

  // A held result blocks input unless it is being consumed this cycle.
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign lane_load   = accept && (state == MAC_ACC_IDLE);
  assign lane_add    = accept && (state == MAC_ACC_ACC);
  assign result_load = accept && in_last;

  assign prod_arr[0] = prod0;
  assign prod_arr[1] = prod1;
  assign prod_arr[2] = prod2;
  assign prod_arr[3] = prod3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      mac_acc_lane #(
        .ACC_WIDTH (ACC_WIDTH),
        .PROD_WIDTH(PROD_WIDTH)
      ) u_lane (
        .clk  (clk),
        .rst  (rst),
        .clear(result_load),
        .load (lane_load),
        .add  (lane_add),
        .prod (prod_arr[gi]),
        .sum  (lane_sum[gi]),
        .ovf  (lane_ovf[gi])
      );
    end
  endgenerate

  // FSM, cfg capture and result registers with the output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MAC_ACC_IDLE;
      cfg_hold  <= MAC_SINGLE;
      out_valid <= 1'b0;
      partial0  <= '0;
      partial1  <= '0;
      partial2  <= '0;
      partial3  <= '0;
      out_cfg   <= MAC_SINGLE;
      ovf       <= '0;
    end else begin
      if (accept) begin
        case (state)
          MAC_ACC_IDLE: begin
            // cfg is only sampled on the first beat; later changes are ignored.
            cfg_hold <= cfg;
            state    <= in_last ? MAC_ACC_IDLE : MAC_ACC_ACC;
          end
          MAC_ACC_ACC: begin
            if (in_last) state <= MAC_ACC_IDLE;
          end
          default: state <= MAC_ACC_IDLE;
        endcase
      end

      if (result_load) begin
        // A new result may replace one being consumed in the same clock.
        out_valid <= 1'b1;
        partial0  <= lane_sum[0];
        partial1  <= lane_sum[1];
        partial2  <= lane_sum[2];
        partial3  <= lane_sum[3];
        out_cfg   <= (state == MAC_ACC_IDLE) ? cfg : cfg_hold;
        ovf       <= lane_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Testbench for mac_accumulator: directed cases with literal expectations plus
// randomized dot products with valid/ready back-pressure against a model that
// keeps exact (unbounded) lane totals.
module tb_mac_accumulator;
  import mac_accumulator_pkg::*;

  localparam int AW = 32;
  localparam int PW = 16;
  localparam longint unsigned LIM = 64'h1_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (32-bit lanes, 16-bit products)
  logic [1:0]    cfg;
  logic          in_valid, in_ready, in_last;
  logic [PW-1:0] prod0, prod1, prod2, prod3;
  logic          out_valid, out_ready;
  logic [AW-1:0] partial0, partial1, partial2, partial3;
  logic [1:0]    out_cfg;
  logic [3:0]    ovf;

  mac_accumulator #(.ACC_WIDTH(AW), .PROD_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .cfg(cfg), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .prod0(prod0), .prod1(prod1), .prod2(prod2), .prod3(prod3),
    .out_valid(out_valid), .out_ready(out_ready), .partial0(partial0),
    .partial1(partial1), .partial2(partial2), .partial3(partial3),
    .out_cfg(out_cfg), .ovf(ovf)
  );

  // Wide-product instance so a lane can reach the carry boundary in two beats
  logic          w_in_valid, w_in_ready, w_in_last, w_out_valid;
  logic [AW-1:0] w_prod0, w_prod1;
  logic [AW-1:0] w_partial0, w_partial1, w_partial2, w_partial3;
  logic [1:0]    w_out_cfg;
  logic [3:0]    w_ovf;

  mac_accumulator #(.ACC_WIDTH(AW), .PROD_WIDTH(AW)) dut_w (
    .clk(clk), .rst(rst), .cfg(MAC_SINGLE), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_last(w_in_last), .prod0(w_prod0), .prod1(w_prod1), .prod2(w_prod1), .prod3(w_prod1),
    .out_valid(w_out_valid), .out_ready(1'b1), .partial0(w_partial0),
    .partial1(w_partial1), .partial2(w_partial2), .partial3(w_partial3),
    .out_cfg(w_out_cfg), .ovf(w_ovf)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint unsigned tot [4];
  bit              in_dot;
  logic [1:0]      cfg_first;
  bit              mvalid;
  logic [AW-1:0]   mpart [4];
  logic [1:0]      mcfg;
  logic [3:0]      movf;
  int              nres;

  function automatic logic [AW-1:0] lane_expect(input longint unsigned t);
`ifdef MAC_ACC_SAT_EN
    return (t >= LIM) ? {AW{1'b1}} : AW'(t);
`else
    return AW'(t);
`endif
  endfunction

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) tot[i] = 0;
      in_dot = 0; mvalid = 0; cfg_first = MAC_SINGLE;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_partials", {partial0, partial1}, 0);
      chk("rst_partials23", {partial2, partial3}, 0);
      chk("rst_out_cfg", out_cfg, MAC_SINGLE);
      chk("rst_ovf", ovf, 0);
    end else begin
      bit exp_ready, take, drain;
      logic [PW-1:0] p [4];
      exp_ready = !mvalid || out_ready;
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, mvalid);
      if (mvalid) begin
        chk("partial0", partial0, mpart[0]);
        chk("partial1", partial1, mpart[1]);
        chk("partial2", partial2, mpart[2]);
        chk("partial3", partial3, mpart[3]);
        chk("out_cfg", out_cfg, mcfg);
        chk("ovf", ovf, movf);
      end
      drain = mvalid && out_ready;
      take  = in_valid && exp_ready;
      p[0] = prod0; p[1] = prod1; p[2] = prod2; p[3] = prod3;
      if (drain) mvalid = 0;
      if (take) begin
        if (!in_dot) begin
          for (int i = 0; i < 4; i++) tot[i] = longint'(p[i]);
          cfg_first = cfg;
        end else begin
          for (int i = 0; i < 4; i++) tot[i] += longint'(p[i]);
        end
        if (in_last) begin
          for (int i = 0; i < 4; i++) begin
            mpart[i] = lane_expect(tot[i]);
            movf[i]  = (tot[i] >= LIM);
          end
          mcfg = cfg_first; mvalid = 1; in_dot = 0; nres++;
        end else begin
          in_dot = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [PW-1:0] a, b, c, d, input logic [1:0] cf, input bit last);
    int n;
    in_valid = 1; prod0 = a; prod1 = b; prod2 = c; prod3 = d; cfg = cf; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin @(negedge clk); n++; end
    chk("beat_accept_timeout", (n < 1000), 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wbeat(input logic [AW-1:0] p, input bit last);
    w_in_valid = 1; w_prod0 = p; w_prod1 = 1; w_in_last = last;
    @(posedge clk); #1;
    w_in_valid = 0; w_in_last = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit rnd_done;

  initial begin
    in_valid = 0; in_last = 0; out_ready = 1; cfg = MAC_SINGLE;
    prod0 = 0; prod1 = 0; prod2 = 0; prod3 = 0;
    w_in_valid = 0; w_in_last = 0; w_prod0 = 0; w_prod1 = 0;
    nres = 0; rnd_done = 0;
    idle(3);
    rst = 1;
    idle(1);

    // Three beats, last on beat 3
    beat(1, 16'h10, 16'h10, 16'h10, MAC_SINGLE, 0);
    beat(2, 16'h10, 16'h10, 16'h10, MAC_SINGLE, 0);
    chk("t1_no_early_valid", out_valid, 0);
    beat(3, 16'h10, 16'h10, 16'h10, MAC_SINGLE, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_partial0", partial0, 6);
    chk("t1_partial1", partial1, 32'h30);
    chk("t1_partial3", partial3, 32'h30);
    idle(1);

    // Single-beat dot product, full-scale products, QUAD cfg
    beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, MAC_QUAD, 1);
    chk("t2_partial0", partial0, 32'h0000FFFF);
    chk("t2_partial2", partial2, 32'h0000FFFF);
    chk("t2_out_cfg", out_cfg, MAC_QUAD);
    idle(1);

    // Held result backpressures, then reloads without a gap
    out_ready = 0;
    beat(5, 5, 5, 5, MAC_DUAL, 1);
    for (int k = 0; k < 10; k++) begin
      idle(1);
      chk("t3_hold_in_ready", in_ready, 0);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_partial0", partial0, 5);
      chk("t3_hold_cfg", out_cfg, MAC_DUAL);
    end
    out_ready = 1;
    beat(7, 7, 7, 7, MAC_QUAD, 1);
    chk("t3_reload_valid", out_valid, 1);
    chk("t3_reload_partial0", partial0, 7);
    chk("t3_reload_cfg", out_cfg, MAC_QUAD);
    idle(2);

    // Reset in the middle of a dot product
    beat(9, 9, 9, 9, MAC_DUAL, 0);
    beat(9, 9, 9, 9, MAC_DUAL, 0);
    #2 rst = 0;
    #1;
    chk("t4_rst_valid", out_valid, 0);
    chk("t4_rst_partial0", partial0, 0);
    chk("t4_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1;
    idle(1);
    beat(1, 2, 3, 4, MAC_SINGLE, 0);
    beat(1, 2, 3, 4, MAC_SINGLE, 0);
    beat(1, 2, 3, 4, MAC_SINGLE, 0);
    beat(1, 2, 3, 4, MAC_SINGLE, 1);
    chk("t4_after_partial0", partial0, 4);
    chk("t4_after_partial3", partial3, 16);
    idle(1);

    // Carry-out on lane 0 (wide instance)
    wbeat(32'hFFFFFFF0, 0);
    wbeat(32'h20, 1);
`ifdef MAC_ACC_SAT_EN
    chk("t5_partial0", w_partial0, 32'hFFFFFFFF);
`else
    chk("t5_partial0", w_partial0, 32'h10);
`endif
    chk("t5_ovf", w_ovf, 4'b0001);
    chk("t5_partial1", w_partial1, 2);
    wbeat(32'hFFFFFFF0, 0);
    wbeat(32'h20, 0);
    wbeat(32'h1, 1);
`ifdef MAC_ACC_SAT_EN
    chk("t5_sticky_partial0", w_partial0, 32'hFFFFFFFF);
`else
    chk("t5_sticky_partial0", w_partial0, 32'h11);
`endif
    chk("t5_sticky_ovf", w_ovf, 4'b0001);
    wbeat(32'h5, 1);
    chk("t5_clear_partial0", w_partial0, 5);
    chk("t5_clear_ovf", w_ovf, 4'b0000);
    chk("t5_valid", w_out_valid, 1);

    // Randomized dot products with back-pressure
    fork
      begin
        for (int d = 0; d < 1000; d++) begin
          int nb;
          nb = $urandom_range(1, 4);
          for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            beat(PW'($urandom), PW'($urandom), PW'($urandom_range(0, 255)), PW'($urandom),
                 2'($urandom_range(0, 2)), (b == nb - 1));
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    idle(4);
    chk("rnd_results_drained", out_valid, 0);
    chk("rnd_result_count_min", (nres >= 1005), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
